tc_mul_arbiter: RTL and testbench
=================================

// Module: tc_mul_arbiter
// PURPOSE
//  Shares one tc_mul pipeline (SHAPE_K-lane FP multiply) between NUM_REQ requesters (warp issue slots).
//  Round-robin arbitration with grant lock until handshake.
//  In-order ID FIFO returns each result to its requester on one tagged response bus.
//  Sits between the warp scheduler's tensor-issue stage and the tc_mul instance.
// PARAMETERS
//  NUM_REQ        4    number of requesters (>=2)
//  SHAPE_K        8    lanes per operand vector
//  ELEMENT_WIDTH  9    bits per lane element
//  TAG_DEPTH      8    max in-flight ops in tc_mul (power of 2)
//  IDW            2    $clog2(NUM_REQ), width of requester id
// PORTS
//  clk            in   1                     clock
//  rst_n          in   1                     synchronous reset, active-low
//  req_valid_i    in   NUM_REQ               per-requester request valid
//  req_ready_o    out  NUM_REQ               per-requester accept (one-hot or zero)
//  req_a_i        in   NUM_REQ*K*EW          operand A vectors, requester r at slice r
//  req_b_i        in   NUM_REQ*K*EW          operand B vectors
//  req_reg_idxw_i in   NUM_REQ*8             destination register index per requester
//  mul_in_valid_o out  1                     to tc_mul in_valid_i
//  mul_in_ready_i in   1                     from tc_mul in_ready_o
//  mul_a_o        out  K*EW                  granted A vector
//  mul_b_o        out  K*EW                  granted B vector
//  mul_out_valid_i in  1                     from tc_mul out_valid_o
//  mul_out_ready_o out 1                     to tc_mul out_ready_i
//  mul_result_i   in   K*EW                  tc_mul result_o
//  mul_fflags_i   in   5                     tc_mul fflags_o
//  resp_valid_o   out  1                     response valid
//  resp_ready_i   in   1                     response accept
//  resp_id_o      out  IDW                   requester owning the response
//  resp_reg_idxw_o out 8                     register index captured at issue
//  resp_result_o  out  K*EW                  result vector
//  resp_fflags_o  out  5                     exception flags
//  err_o          out  1                     sticky: tc_mul output with empty ID FIFO
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): rr_ptr=0, state=ARB, FIFO empty, err_o=0, all valid/ready outputs 0.
//  FSM ARB: grant = first r with req_valid_i[r], searching from rr_ptr upward with wrap.
//    - Issue iff grant exists, FIFO not full, mul_in_ready_i=1.
//    - On issue: push {grant, reg_idxw} to FIFO; rr_ptr=(grant+1)%NUM_REQ; stay ARB.
//    - Grant but no issue -> HOLD with locked_id=grant.
//  FSM HOLD: grant = locked_id regardless of other requests.
//    - On issue: rr_ptr=(locked_id+1)%NUM_REQ, go to ARB.
//    - If req_valid_i[locked_id] drops (protocol violation), go to ARB with no push.
//  mul_in_valid_o = grant exists && FIFO not full. mul_a_o/mul_b_o = granted slices, 0 when no grant.
//  req_ready_o[g] = mul_in_valid_o && mul_in_ready_i for grant g; other bits 0. Zero-cycle issue latency.
//  Response path is combinational pass-through, no added latency:
//    - resp_valid_o = mul_out_valid_i && FIFO not empty.
//    - mul_out_ready_o = resp_ready_i && FIFO not empty.
//    - resp_id_o/resp_reg_idxw_o = FIFO head. Pop on resp_valid_o && resp_ready_i.
//  FIFO: occupancy counter 0..TAG_DEPTH; wrap-around read/write pointers.
//    - Simultaneous push+pop: count unchanged.
//    - When full, push is blocked even if a pop occurs the same cycle (no combinational pop->push path).
//  mul_out_valid_i=1 with FIFO empty: err_o set and held until reset; output not consumed.
//  Reset mid-operation: FIFO and FSM cleared. Pipeline contents inside tc_mul are flushed by the shared rst_n.
// CONFIGURATION
//  TC_MUL_ARB_PERF_EN defined: adds ports perf_issue_o[31:0] and perf_stall_o[31:0].
//    - perf_issue_o counts issues.
//    - perf_stall_o counts cycles with any req_valid_i and no issue.
//    - Both wrap at 2^32 and reset to 0.
//  TC_MUL_ARB_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  T1 reset: rst_n=0 for 2 cycles with all req_valid_i=1 -> every output 0. First post-reset grant is r0.
//  T2 fairness: all 4 requesters held valid, mul_in_ready_i=1 -> grants 0,1,2,3,0,1 on consecutive cycles.
//  T3 lock: r2 valid, mul_in_ready_i=0 for 3 cycles, r0 asserts in cycle 2 -> grant stays 2, issues when ready=1. Next grant is r0.
//  T4 full: TAG_DEPTH=8, 8 issues with resp_ready_i=0 -> mul_in_valid_o=0 on the 9th request. One pop -> issue resumes next cycle.
//  T5 routing: issue r3 (idxw=0x15) then r1 (idxw=0x07), results A,B -> resp (id3,0x15,A) then (id1,0x07,B). resp_ready_i stalls hold data stable.
//  T6 error: mul_out_valid_i=1 with FIFO empty -> err_o=1 from next cycle, stays 1 until rst_n=0.

Source files
------------

// File: rtl/tc_mul_arbiter_if.sv
// Bundle of the requester, tc_mul and response buses around tc_mul_arbiter.
// slave  : seen from the arbiter.
// master : seen from the surrounding environment (scheduler, tc_mul, consumer).
interface tc_mul_arbiter_if #(
   parameter int NUM_REQ       = 4,
   parameter int SHAPE_K       = 8,
   parameter int ELEMENT_WIDTH = 9,
   parameter int IDW           = $clog2(NUM_REQ)
);
   localparam int VW = SHAPE_K * ELEMENT_WIDTH;

   logic [NUM_REQ-1:0]    req_valid_i;
   logic [NUM_REQ-1:0]    req_ready_o;
   logic [NUM_REQ*VW-1:0] req_a_i;
   logic [NUM_REQ*VW-1:0] req_b_i;
   logic [NUM_REQ*8-1:0]  req_reg_idxw_i;
   logic                  mul_in_valid_o;
   logic                  mul_in_ready_i;
   logic [VW-1:0]         mul_a_o;
   logic [VW-1:0]         mul_b_o;
   logic                  mul_out_valid_i;
   logic                  mul_out_ready_o;
   logic [VW-1:0]         mul_result_i;
   logic [4:0]            mul_fflags_i;
   logic                  resp_valid_o;
   logic                  resp_ready_i;
   logic [IDW-1:0]        resp_id_o;
   logic [7:0]            resp_reg_idxw_o;
   logic [VW-1:0]         resp_result_o;
   logic [4:0]            resp_fflags_o;
   logic                  err_o;

   modport slave (
      input  req_valid_i, req_a_i, req_b_i, req_reg_idxw_i,
      input  mul_in_ready_i, mul_out_valid_i, mul_result_i, mul_fflags_i,
      input  resp_ready_i,
      output req_ready_o, mul_in_valid_o, mul_a_o, mul_b_o, mul_out_ready_o,
      output resp_valid_o, resp_id_o, resp_reg_idxw_o, resp_result_o, resp_fflags_o,
      output err_o
   );

   modport master (
      output req_valid_i, req_a_i, req_b_i, req_reg_idxw_i,
      output mul_in_ready_i, mul_out_valid_i, mul_result_i, mul_fflags_i,
      output resp_ready_i,
      input  req_ready_o, mul_in_valid_o, mul_a_o, mul_b_o, mul_out_ready_o,
      input  resp_valid_o, resp_id_o, resp_reg_idxw_o, resp_result_o, resp_fflags_o,
      input  err_o
   );
endinterface

// File: rtl/tc_mul_arbiter.sv
// tc_mul_arbiter: round-robin sharing of one tc_mul pipeline between NUM_REQ
// requesters. A grant is locked until its handshake completes; an in-order ID
// FIFO tags each returning result with its requester and register index.
// Optional macro TC_MUL_ARB_PERF_EN adds issue/stall performance counters.
module tc_mul_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int SHAPE_K       = 8,
   parameter int ELEMENT_WIDTH = 9,
   parameter int TAG_DEPTH     = 8,
   parameter int IDW           = $clog2(NUM_REQ)
) (
   input logic             clk,
   input logic             rst_n,
   tc_mul_arbiter_if.slave bus
`ifdef TC_MUL_ARB_PERF_EN
   ,
   output logic [31:0]     perf_issue_o,
   output logic [31:0]     perf_stall_o
`endif
);
   localparam int VW = SHAPE_K * ELEMENT_WIDTH;
   localparam int PW = $clog2(TAG_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {ARB, HOLD} state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] locked_q, locked_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;
   logic [IDW-1:0] id_mem_q  [TAG_DEPTH];
   logic [7:0]     idx_mem_q [TAG_DEPTH];

   logic           grant_vld;
   logic [IDW-1:0] grant_id;
   logic [IDW-1:0] rr_next;
   logic [7:0]     grant_idxw;
   logic           fifo_full, fifo_nempty;
   logic           issue, pop, resp_vld;

   // Grant selection: locked requester in HOLD, else first valid from rr_ptr with wrap
   always_comb begin
      int             pos;
      logic [IDW-1:0] cand;
      grant_vld = 1'b0;
      grant_id  = '0;
      pos       = 0;
      cand      = '0;
      if (state_q == HOLD) begin
         grant_vld = bus.req_valid_i[locked_q];
         grant_id  = locked_q;
      end else begin
         // Descending scan so the smallest offset from rr_ptr wins
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = int'(rr_ptr_q) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            cand = IDW'(pos);
            if (bus.req_valid_i[cand]) begin
               grant_vld = 1'b1;
               grant_id  = cand;
            end
         end
      end
      // Outputs stay quiet while reset is asserted
      grant_vld = grant_vld && rst_n;
   end

   assign rr_next     = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
   assign fifo_full   = (cnt_q == CW'(TAG_DEPTH));
   assign fifo_nempty = (cnt_q != '0);
   assign issue       = grant_vld && !fifo_full && bus.mul_in_ready_i;
   assign resp_vld    = rst_n && bus.mul_out_valid_i && fifo_nempty;
   assign pop         = resp_vld && bus.resp_ready_i;

   // Issue-side outputs: granted operand slices and one-hot accept
   always_comb begin
      bus.mul_a_o     = '0;
      bus.mul_b_o     = '0;
      bus.req_ready_o = '0;
      grant_idxw      = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (grant_vld && grant_id == IDW'(r)) begin
            bus.mul_a_o = bus.req_a_i[r*VW +: VW];
            bus.mul_b_o = bus.req_b_i[r*VW +: VW];
            grant_idxw  = bus.req_reg_idxw_i[r*8 +: 8];
            bus.req_ready_o[r] = issue;
         end
      end
   end

   assign bus.mul_in_valid_o  = grant_vld && !fifo_full;
   assign bus.mul_out_ready_o = rst_n && bus.resp_ready_i && fifo_nempty;
   assign bus.resp_valid_o    = resp_vld;
   assign bus.resp_id_o       = id_mem_q[rd_ptr_q];
   assign bus.resp_reg_idxw_o = idx_mem_q[rd_ptr_q];
   assign bus.resp_result_o   = bus.mul_result_i;
   assign bus.resp_fflags_o   = bus.mul_fflags_i;
   assign bus.err_o           = err_q;

   // FSM next state: lock on a stalled grant, release on handshake or dropped request
   always_comb begin
      state_d  = state_q;
      locked_d = locked_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ARB: begin
            if (issue) begin
               rr_ptr_d = rr_next;
            end else if (grant_vld) begin
               state_d  = HOLD;
               locked_d = grant_id;
            end
         end
         HOLD: begin
            if (!grant_vld) begin
               state_d = ARB;
            end else if (issue) begin
               rr_ptr_d = rr_next;
               state_d  = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ARB;
         rr_ptr_q <= '0;
         locked_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         locked_q <= locked_d;
      end
   end

   // FIFO pointer/occupancy and sticky error next state
   always_comb begin
      wr_ptr_d = issue ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (issue && !pop) cnt_d = cnt_q + CW'(1);
      if (!issue && pop) cnt_d = cnt_q - CW'(1);
      err_d    = err_q || (bus.mul_out_valid_i && !fifo_nempty);
   end

   // FIFO control and error registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // FIFO storage: requester id and destination register captured at issue
   always_ff @(posedge clk) begin
      if (issue) begin
         id_mem_q[wr_ptr_q]  <= grant_id;
         idx_mem_q[wr_ptr_q] <= grant_idxw;
      end
   end

`ifdef TC_MUL_ARB_PERF_EN
   logic [31:0] perf_issue_q, perf_stall_q;

   // Free-running wrap-around counters of issues and stalled request cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_issue_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (issue) perf_issue_q <= perf_issue_q + 32'd1;
         if ((|bus.req_valid_i) && !issue) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_issue_o = perf_issue_q;
   assign perf_stall_o = perf_stall_q;
`endif
endmodule

// File: tb/tb_tc_mul_arbiter.sv
// Scoreboard bench for tc_mul_arbiter: expected issues and responses are queued
// by the stimulus; two negedge monitors pop and compare on every handshake.
module tb_tc_mul_arbiter;
   localparam int NR = 4;
   localparam int K  = 8;
   localparam int EW = 9;
   localparam int VW = K * EW;

   typedef struct {
      int          id;
      logic [7:0]  idx;
      logic [VW-1:0] res;
      logic [4:0]  ff;
   } resp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_total = 0;
   int   n_pass  = 0;
   int   exp_issue[$];
   resp_t exp_resp[$];

   tc_mul_arbiter_if #(.NUM_REQ(NR), .SHAPE_K(K), .ELEMENT_WIDTH(EW)) bus ();

   tc_mul_arbiter #(.NUM_REQ(NR), .SHAPE_K(K), .ELEMENT_WIDTH(EW), .TAG_DEPTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] pat_a(input int r);
      logic [VW-1:0] v;
      for (int l = 0; l < K; l++) v[l*EW +: EW] = 9'(r * 32 + l + 1);
      return v;
   endfunction

   function automatic logic [VW-1:0] pat_b(input int r);
      logic [VW-1:0] v;
      for (int l = 0; l < K; l++) v[l*EW +: EW] = 9'(256 + r * 16 + l);
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle_inputs();
      bus.req_valid_i     = '0;
      bus.mul_in_ready_i  = 1'b0;
      bus.mul_out_valid_i = 1'b0;
      bus.mul_result_i    = '0;
      bus.mul_fflags_i    = '0;
      bus.resp_ready_i    = 1'b0;
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Issue monitor: every accepted request must match the next expected grant
   always @(negedge clk) begin
      if (rst_n && bus.mul_in_valid_o && bus.mul_in_ready_i) begin
         if (exp_issue.size() == 0) begin
            chk("issue_unexpected_qsize", 128'(exp_issue.size()), 128'd1);
         end else begin
            int g;
            g = exp_issue.pop_front();
            chk("issue_ready_onehot", 128'(bus.req_ready_o), 128'(4'b0001 << g));
            chk("issue_mul_a", 128'(bus.mul_a_o), 128'(pat_a(g)));
            chk("issue_mul_b", 128'(bus.mul_b_o), 128'(pat_b(g)));
         end
      end
   end

   // Response monitor: every consumed response must match the next expected tag/data
   always @(negedge clk) begin
      if (rst_n && bus.resp_valid_o && bus.resp_ready_i) begin
         if (exp_resp.size() == 0) begin
            chk("resp_unexpected_qsize", 128'(exp_resp.size()), 128'd1);
         end else begin
            resp_t e;
            e = exp_resp.pop_front();
            chk("resp_id", 128'(bus.resp_id_o), 128'(e.id));
            chk("resp_idxw", 128'(bus.resp_reg_idxw_o), 128'(e.idx));
            chk("resp_result", 128'(bus.resp_result_o), 128'(e.res));
            chk("resp_fflags", 128'(bus.resp_fflags_o), 128'(e.ff));
            chk("resp_mul_out_ready", 128'(bus.mul_out_ready_o), 128'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int r = 0; r < NR; r++) begin
         bus.req_a_i[r*VW +: VW] = pat_a(r);
         bus.req_b_i[r*VW +: VW] = pat_b(r);
      end
      bus.req_reg_idxw_i = {8'h15, 8'h2A, 8'h07, 8'h20};
      idle_inputs();

      // T1: reset with every requester valid; all outputs quiet
      rst_n = 1'b0;
      bus.req_valid_i    = 4'hF;
      bus.mul_in_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 128'(bus.req_ready_o), 128'd0);
      chk("rst_mul_in_valid", 128'(bus.mul_in_valid_o), 128'd0);
      chk("rst_mul_out_ready", 128'(bus.mul_out_ready_o), 128'd0);
      chk("rst_resp_valid", 128'(bus.resp_valid_o), 128'd0);
      chk("rst_err", 128'(bus.err_o), 128'd0);
      chk("rst_mul_a", 128'(bus.mul_a_o), 128'd0);

      // T2: fairness, grants 0,1,2,3,0,1 back to back (first after reset is r0)
      @(posedge clk); #1;
      exp_issue.push_back(0); exp_issue.push_back(1); exp_issue.push_back(2);
      exp_issue.push_back(3); exp_issue.push_back(0); exp_issue.push_back(1);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 idle_inputs();

      // T3: grant lock on r2 while r0 joins, then r0 next
      assert_reset();
      bus.req_valid_i = 4'b0100;
      rst_n = 1'b1;
      @(negedge clk);
      chk("lock_c1_valid", 128'(bus.mul_in_valid_o), 128'd1);
      chk("lock_c1_a", 128'(bus.mul_a_o), 128'(pat_a(2)));
      @(posedge clk); #1;
      bus.req_valid_i = 4'b0101;
      @(negedge clk);
      chk("lock_c2_a", 128'(bus.mul_a_o), 128'(pat_a(2)));
      chk("lock_c2_ready", 128'(bus.req_ready_o), 128'd0);
      @(negedge clk);
      chk("lock_c3_a", 128'(bus.mul_a_o), 128'(pat_a(2)));
      @(posedge clk); #1;
      exp_issue.push_back(2); exp_issue.push_back(0);
      bus.mul_in_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 idle_inputs();

      // T4: FIFO full after 8 issues; one pop, issue resumes the cycle after
      assert_reset();
      bus.req_valid_i    = 4'b0001;
      bus.mul_in_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) exp_issue.push_back(0);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("full_in_valid", 128'(bus.mul_in_valid_o), 128'd0);
      chk("full_req_ready", 128'(bus.req_ready_o), 128'd0);
      @(posedge clk); #1;
      exp_resp.push_back('{id: 0, idx: 8'h20, res: 72'h0AB_CDE_F01_234_567_89A, ff: 5'h00});
      exp_issue.push_back(0);
      bus.mul_out_valid_i = 1'b1;
      bus.mul_result_i    = 72'h0AB_CDE_F01_234_567_89A;
      bus.resp_ready_i    = 1'b1;
      @(negedge clk);
      chk("full_pop_no_push", 128'(bus.mul_in_valid_o), 128'd0);
      @(posedge clk); #1;
      bus.mul_out_valid_i = 1'b0;
      bus.resp_ready_i    = 1'b0;
      @(negedge clk);
      chk("full_resume_valid", 128'(bus.mul_in_valid_o), 128'd1);
      @(posedge clk); #1 idle_inputs();

      // T5: routing r3 (0x15) then r1 (0x07), stalled response held stable
      assert_reset();
      bus.req_valid_i    = 4'b1000;
      bus.mul_in_ready_i = 1'b1;
      exp_issue.push_back(3); exp_issue.push_back(1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.req_valid_i = 4'b0010;
      @(posedge clk); #1;
      bus.req_valid_i = 4'b0000;
      exp_resp.push_back('{id: 3, idx: 8'h15, res: 72'h111_222_333_444_555_666, ff: 5'h03});
      exp_resp.push_back('{id: 1, idx: 8'h07, res: 72'h1FF_000_1FF_000_123_045, ff: 5'h10});
      bus.mul_out_valid_i = 1'b1;
      bus.mul_result_i    = 72'h111_222_333_444_555_666;
      bus.mul_fflags_i    = 5'h03;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("stall_resp_valid", 128'(bus.resp_valid_o), 128'd1);
         chk("stall_resp_id", 128'(bus.resp_id_o), 128'd3);
         chk("stall_resp_idxw", 128'(bus.resp_reg_idxw_o), 128'h15);
         chk("stall_result", 128'(bus.resp_result_o), 128'h111_222_333_444_555_666);
         chk("stall_mul_out_ready", 128'(bus.mul_out_ready_o), 128'd0);
      end
      @(posedge clk); #1;
      bus.resp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.mul_result_i = 72'h1FF_000_1FF_000_123_045;
      bus.mul_fflags_i = 5'h10;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("route_drained_valid", 128'(bus.resp_valid_o), 128'd0);
      chk("route_err", 128'(bus.err_o), 128'd0);

      // T6: result with empty FIFO sets sticky error, cleared only by reset
      assert_reset();
      bus.mul_out_valid_i = 1'b1;
      bus.resp_ready_i    = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("err_before", 128'(bus.err_o), 128'd0);
      chk("err_not_consumed", 128'(bus.mul_out_ready_o), 128'd0);
      chk("err_no_resp", 128'(bus.resp_valid_o), 128'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("err_set", 128'(bus.err_o), 128'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("err_sticky", 128'(bus.err_o), 128'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("err_cleared", 128'(bus.err_o), 128'd0);

      chk("issue_queue_empty", 128'(exp_issue.size()), 128'd0);
      chk("resp_queue_empty", 128'(exp_resp.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
